imp_norm_div: RTL and testbench

Normalization divider for the ImprovedAILN datapath. It acts as the initiator and consumer of the integer square-root unit's start/done interface. Per frame it accepts a 16-bit variance, launches the sqrt unit, and captures the 8-bit standard deviation. It then divides NUM_ELEM signed deviation values (x − mean) by that standard deviation with a sequential restoring divider, emitting signed fixed-point normalized results over a valid/ready stream.

---
 rtl/imp_norm_div_if.sv | 35 +++
 rtl/imp_norm_div.sv | 192 +++++++++++++++++++
 tb/tb_imp_norm_div.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/imp_norm_div_if.sv
// Handshake bundle between the normalization divider, its sqrt unit and the
// deviation/result streams. The slave modport is the divider's view.
interface imp_norm_div_if;
    logic        i_var_valid;
    logic [15:0] i_var;
    logic        o_var_ready;

    logic        o_sqrt_start;
    logic [15:0] o_sqrt_data;
    logic        i_sqrt_done;
    logic [7:0]  i_sqrt;

    logic        i_dev_valid;
    logic [15:0] i_dev;
    logic        o_dev_ready;

    logic        o_norm_valid;
    logic [15:0] o_norm;
    logic        i_norm_ready;

    logic        o_div0;
    logic        o_frame_done;

    modport slave (
        input  i_var_valid, i_var, i_sqrt_done, i_sqrt, i_dev_valid, i_dev, i_norm_ready,
        output o_var_ready, o_sqrt_start, o_sqrt_data, o_dev_ready, o_norm_valid, o_norm,
               o_div0, o_frame_done
    );

    modport master (
        output i_var_valid, i_var, i_sqrt_done, i_sqrt, i_dev_valid, i_dev, i_norm_ready,
        input  o_var_ready, o_sqrt_start, o_sqrt_data, o_dev_ready, o_norm_valid, o_norm,
               o_div0, o_frame_done
    );
endinterface

// File: rtl/imp_norm_div.sv
// Per-frame normalization: variance -> sqrt unit -> std, then each signed
// deviation is divided by std with a bit-serial restoring divider.
module imp_norm_div #(
    parameter int NUM_ELEM = 8,
    parameter int FRAC     = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    imp_norm_div_if.slave  bus
);
    localparam int DIV_BITS = 16 + FRAC;
    localparam int ITER_W   = $clog2(DIV_BITS + 1);
    localparam int CNT_W    = $clog2(NUM_ELEM + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQRT_REQ,
        S_SQRT_WAIT,
        S_DEV_WAIT,
        S_DIVIDE,
        S_OUTPUT
    } state_t;

    state_t state_reg, state_next;

    logic [15:0]         var_reg;
    logic [7:0]          std_reg;
    logic                div0_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                sign_reg;
    logic [DIV_BITS-1:0] work_reg;
    logic [7:0]          rem_reg;
    logic [ITER_W-1:0]   iter_reg;
    logic [15:0]         norm_reg;
    logic                frame_done_reg;

    logic var_ready, sqrt_start, dev_ready, norm_valid;

    // Handshake qualifiers shared by the FSM and the datapath
    logic var_fire, sqrt_fire, dev_fire, out_fire;
    logic last_iter, last_elem;
    logic [CNT_W-1:0] cnt_inc;

    assign var_fire  = (state_reg == S_IDLE)      && bus.i_var_valid;
    assign sqrt_fire = (state_reg == S_SQRT_WAIT) && bus.i_sqrt_done;
    assign dev_fire  = (state_reg == S_DEV_WAIT)  && bus.i_dev_valid;
    assign out_fire  = (state_reg == S_OUTPUT)    && bus.i_norm_ready;
    assign last_iter = (iter_reg == ITER_W'(DIV_BITS - 1));
    assign cnt_inc   = cnt_reg + CNT_W'(1);
    assign last_elem = (cnt_inc == CNT_W'(NUM_ELEM));

    // -32768 becomes 0x8000, which is read as unsigned 32768 from here on
    logic [15:0] dev_mag;
    assign dev_mag = bus.i_dev[15] ? (~bus.i_dev + 16'd1) : bus.i_dev;

    // One restoring step: a borrow out of the 9-bit trial subtraction means
    // the divisor did not fit, so the quotient bit is 0 and the remainder is kept.
    logic [8:0]          trial;
    logic [8:0]          diff;
    logic                qbit;
    logic [7:0]          rem_next;
    logic [DIV_BITS-1:0] work_next;

    assign trial     = {rem_reg, work_reg[DIV_BITS-1]};
    assign diff      = trial - {1'b0, std_reg};
    assign qbit      = ~diff[8];
    assign rem_next  = qbit ? diff[7:0] : trial[7:0];
    assign work_next = {work_reg[DIV_BITS-2:0], qbit};

    // Final quotient is work_next on the last step; saturate then apply sign
    logic [15:0] quot_sat;
    logic [15:0] quot_signed;

    assign quot_sat    = (|work_next[DIV_BITS-1:15]) ? 16'h7FFF : {1'b0, work_next[14:0]};
    assign quot_signed = sign_reg ? (~quot_sat + 16'd1) : quot_sat;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        var_ready  = 1'b0;
        sqrt_start = 1'b0;
        dev_ready  = 1'b0;
        norm_valid = 1'b0;
        case (state_reg)
            S_IDLE: begin
                var_ready = ~i_rst;
                if (bus.i_var_valid) begin
                    state_next = S_SQRT_REQ;
                end
            end
            S_SQRT_REQ: begin
                sqrt_start = 1'b1;
                state_next = S_SQRT_WAIT;
            end
            S_SQRT_WAIT: begin
                if (bus.i_sqrt_done) begin
                    state_next = S_DEV_WAIT;
                end
            end
            S_DEV_WAIT: begin
                dev_ready = 1'b1;
                if (bus.i_dev_valid) begin
                    state_next = div0_reg ? S_OUTPUT : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (last_iter) begin
                    state_next = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                norm_valid = 1'b1;
                if (bus.i_norm_ready) begin
                    state_next = last_elem ? S_IDLE : S_DEV_WAIT;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            var_reg        <= '0;
            std_reg        <= '0;
            div0_reg       <= 1'b0;
            cnt_reg        <= '0;
            sign_reg       <= 1'b0;
            work_reg       <= '0;
            rem_reg        <= '0;
            iter_reg       <= '0;
            norm_reg       <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;

            if (var_fire) begin
                var_reg <= bus.i_var;
            end

            if (sqrt_fire) begin
                std_reg  <= bus.i_sqrt;
                div0_reg <= (bus.i_sqrt == 8'd0);
                cnt_reg  <= '0;
            end

            if (dev_fire) begin
                sign_reg <= bus.i_dev[15];
                work_reg <= DIV_BITS'(dev_mag) << FRAC;
                rem_reg  <= '0;
                iter_reg <= '0;
                if (div0_reg) begin
                    norm_reg <= '0;
                end
            end

            if (state_reg == S_DIVIDE) begin
                work_reg <= work_next;
                rem_reg  <= rem_next;
                iter_reg <= iter_reg + ITER_W'(1);
                if (last_iter) begin
                    norm_reg <= quot_signed;
                end
            end

            if (out_fire) begin
                cnt_reg <= cnt_inc;
                if (last_elem) begin
                    frame_done_reg <= 1'b1;
                    div0_reg       <= 1'b0;
                end
            end
        end
    end

    assign bus.o_var_ready  = var_ready;
    assign bus.o_sqrt_start = sqrt_start;
    assign bus.o_sqrt_data  = var_reg;
    assign bus.o_dev_ready  = dev_ready;
    assign bus.o_norm_valid = norm_valid;
    assign bus.o_norm       = norm_reg;
    assign bus.o_div0       = div0_reg;
    assign bus.o_frame_done = frame_done_reg;
endmodule

// File: tb/tb_imp_norm_div.sv
// Directed bench for imp_norm_div: table of frames with hand-computed results,
// plus backpressure and mid-divide reset sequences. Includes a 3-cycle sqrt model.
module tb_imp_norm_div;
    localparam int NE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imp_norm_div_if bus ();

    imp_norm_div #(.NUM_ELEM(NE), .FRAC(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0]         var_v;
        logic [7:0]          std_v;
        logic [NE-1:0][15:0] dev;
        logic [NE-1:0][15:0] want;
        int                  lat;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int start_count = 0;
    int fd_count = 0;
    logic [15:0] exp_var_v = 16'h0;
    logic [7:0]  sqrt_resp = 8'h0;
    bit          sqrt_bad = 1'b0;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] v, input logic [7:0] s,
                                input logic [15:0] d0, d1, d2, d3,
                                input logic [15:0] w0, w1, w2, w3, input int lat);
        vec_t r;
        r.var_v = v; r.std_v = s; r.lat = lat;
        r.dev[0] = d0; r.dev[1] = d1; r.dev[2] = d2; r.dev[3] = d3;
        r.want[0] = w0; r.want[1] = w1; r.want[2] = w2; r.want[3] = w3;
        return r;
    endfunction

    // Sqrt unit model: done one-cycle pulse three cycles after the start cycle
    initial begin
        bus.i_sqrt_done = 1'b0;
        bus.i_sqrt      = 8'hA5;
        forever begin
            @(negedge clk);
            if (bus.o_sqrt_start && !rst) begin
                start_count++;
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) @(negedge clk);
                    if (bus.o_sqrt_data !== exp_var_v) sqrt_bad = 1'b1;
                    if (k > 0 && bus.o_sqrt_start) sqrt_bad = 1'b1;
                end
                bus.i_sqrt_done = 1'b1;
                bus.i_sqrt      = sqrt_resp;
                @(negedge clk);
                bus.i_sqrt_done = 1'b0;
                bus.i_sqrt      = 8'hA5;
                if (!bus.o_dev_ready) sqrt_bad = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.o_frame_done) fd_count++;
    end

    task automatic wait_var_ready();
        int n = 0;
        while (!bus.o_var_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("var_ready_wait", bus.o_var_ready, 1);
    endtask

    task automatic wait_dev_ready();
        int n = 0;
        while (!bus.o_dev_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("dev_ready_wait", bus.o_dev_ready, 1);
    endtask

    task automatic offer_var(input logic [15:0] v);
        wait_var_ready();
        bus.i_var_valid = 1'b1;
        bus.i_var       = v;
        @(posedge clk);
        @(negedge clk);
        bus.i_var_valid = 1'b0;
        bus.i_var       = 16'hFFFF;
    endtask

    // Called at a negedge with o_dev_ready high; returns after the result is accepted
    task automatic send_dev(input logic [15:0] d, input int bp, output logic [15:0] res, output int lat);
        bus.i_norm_ready = (bp == 0);
        bus.i_dev_valid  = 1'b1;
        bus.i_dev        = d;
        @(posedge clk);
        @(negedge clk);
        bus.i_dev_valid = 1'b0;
        bus.i_dev       = 16'h1234;
        lat = 1;
        while (!bus.o_norm_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = bus.o_norm;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check("bp_hold", {bus.o_norm_valid, bus.o_dev_ready, bus.o_norm}, {2'b10, res});
        end
        bus.i_norm_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input vec_t v, input int fidx, input int bp_elem, input int bp);
        int sc0 = start_count;
        int fd0 = fd_count;
        logic [15:0] res;
        int lat;
        exp_var_v = v.var_v;
        sqrt_resp = v.std_v;
        sqrt_bad  = 1'b0;
        offer_var(v.var_v);
        for (int i = 0; i < NE; i++) begin
            wait_dev_ready();
            if (i == 0) check("div0", bus.o_div0, (v.std_v == 8'd0));
            send_dev(v.dev[i], (i == bp_elem) ? bp : 0, res, lat);
            $display("frame %0d elem %0d: dev=%h std=%0d norm=%h lat=%0d", fidx, i, v.dev[i], v.std_v, res, lat);
            check("norm", res, v.want[i]);
            check("latency", lat, v.lat);
            check("frame_done", bus.o_frame_done, (i == NE - 1));
        end
        check("var_ready_after", bus.o_var_ready, 1);
        check("div0_cleared", bus.o_div0, 0);
        @(negedge clk);
        check("frame_done_count", fd_count - fd0, 1);
        check("sqrt_start_count", start_count - sc0, 1);
        check("sqrt_iface", sqrt_bad, 0);
    endtask

    initial begin
        logic [15:0] res;
        int lat;
        int fd0;

        bus.i_var_valid  = 1'b0;
        bus.i_var        = 16'h0;
        bus.i_dev_valid  = 1'b0;
        bus.i_dev        = 16'h0;
        bus.i_norm_ready = 1'b1;

        tbl[0] = mk(16'd16,    8'd4,   16'd8, 16'hFFFD, 16'hFFFF, 16'h0000,
                                       16'h0200, 16'hFF40, 16'hFFC0, 16'h0000, 25);
        tbl[1] = mk(16'd0,     8'd0,   16'd100, 16'hFFFB, 16'h7FFF, 16'h8000,
                                       16'h0000, 16'h0000, 16'h0000, 16'h0000, 1);
        tbl[2] = mk(16'd1,     8'd1,   16'd200, 16'hFF38, 16'h8000, 16'd1,
                                       16'h7FFF, 16'h8001, 16'h8001, 16'h0100, 25);
        tbl[3] = mk(16'd9,     8'd3,   16'd1, 16'hFFFF, 16'd100, 16'hFFF9,
                                       16'h0055, 16'hFFAB, 16'h2155, 16'hFDAB, 25);
        tbl[4] = mk(16'd65025, 8'd255, 16'h7FFF, 16'hFF01, 16'd1, 16'hFFFF,
                                       16'h7FFF, 16'hFF00, 16'h0001, 16'hFFFF, 25);

        repeat (2) @(negedge clk);
        check("rst_var_ready", bus.o_var_ready, 0);
        check("rst_outputs", {bus.o_sqrt_start, bus.o_dev_ready, bus.o_norm_valid, bus.o_div0,
                              bus.o_frame_done, bus.o_sqrt_data, bus.o_norm}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_var_ready", bus.o_var_ready, 1);

        for (int f = 0; f < 5; f++) begin
            run_frame(tbl[f], f, -1, 0);
        end

        // Reset in the middle of a division
        exp_var_v = 16'd16;
        sqrt_resp = 8'd4;
        fd0 = fd_count;
        offer_var(16'd16);
        wait_dev_ready();
        bus.i_dev_valid = 1'b1;
        bus.i_dev       = 16'd8;
        @(posedge clk);
        @(negedge clk);
        bus.i_dev_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        $display("reset asserted mid-divide");
        check("midrst_norm", bus.o_norm, 0);
        check("midrst_sqrt_data", bus.o_sqrt_data, 0);
        check("midrst_ctrl", {bus.o_var_ready, bus.o_dev_ready, bus.o_norm_valid,
                              bus.o_sqrt_start, bus.o_div0, bus.o_frame_done}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_no_done", fd_count - fd0, 0);
        check("midrst_idle", {bus.o_var_ready, bus.o_norm_valid}, 2'b10);
        run_frame(tbl[3], 5, -1, 0);

        // Backpressure on the second element
        run_frame(tbl[0], 6, 1, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end
endmodule
